// File: rtl/zeroriscy_dmem_pkg.sv
// Shared types and default address map for the zero-riscy data-side memory bridge.
// Also used by the address decoder, which is reusable on the instruction side.
package zeroriscy_dmem_pkg;

    localparam int unsigned DefaultSramAw   = 12;
    localparam logic [31:0] DefaultSramBase = 32'h0010_0000;
    localparam logic [31:0] DefaultPerBase  = 32'h1A00_0000;
    localparam logic [31:0] DefaultPerMask  = 32'hFF00_0000;

    // Bridge FSM encoding
    typedef logic [2:0] dmem_state_t;
    localparam dmem_state_t StIdle    = 3'd0;
    localparam dmem_state_t StSramRsp = 3'd1;
    localparam dmem_state_t StPerWait = 3'd2;
    localparam dmem_state_t StPerRsp  = 3'd3;
    localparam dmem_state_t StErrRsp  = 3'd4;

    typedef enum logic [1:0] {
        TgtSram,
        TgtPer,
        TgtNone
    } dmem_tgt_e;

endpackage

// File: rtl/zeroriscy_dmem_bridge_if.sv
// req/gnt/rvalid data bus as used by the zero-riscy LSU and the peripheral side.
// The master issues requests; the slave grants and returns responses.
interface zeroriscy_dmem_bridge_if;

    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, err, rdata
    );

endinterface

// File: rtl/zeroriscy_dmem_decode.sv
// Combinational address-to-target decoder: SRAM window first, then the
// peripheral window, everything else is unmapped.
module zeroriscy_dmem_decode
    import zeroriscy_dmem_pkg::*;
#(
    parameter int unsigned SRAM_AW   = DefaultSramAw,
    parameter logic [31:0] SRAM_BASE = DefaultSramBase,
    parameter logic [31:0] PER_BASE  = DefaultPerBase,
    parameter logic [31:0] PER_MASK  = DefaultPerMask
) (
    input  logic [31:0] addr_i,
    output dmem_tgt_e   tgt_o
);

    always_comb begin
        if (addr_i[31:SRAM_AW+2] == SRAM_BASE[31:SRAM_AW+2]) begin
            tgt_o = TgtSram;
        end else if ((addr_i & PER_MASK) == PER_BASE) begin
            tgt_o = TgtPer;
        end else begin
            tgt_o = TgtNone;
        end
    end

endmodule

// File: rtl/zeroriscy_dmem_bridge.sv
// Data-side bridge from the zero-riscy LSU to a local SRAM, a peripheral bus or an
// error responder. One transaction outstanding; a new one may be granted in a response cycle.
module zeroriscy_dmem_bridge
    import zeroriscy_dmem_pkg::*;
#(
    parameter int unsigned SRAM_AW   = DefaultSramAw,
    parameter logic [31:0] SRAM_BASE = DefaultSramBase,
    parameter logic [31:0] PER_BASE  = DefaultPerBase,
    parameter logic [31:0] PER_MASK  = DefaultPerMask
) (
    input  logic                   clk,
    input  logic                   rst,
    zeroriscy_dmem_bridge_if.slave  data,
    zeroriscy_dmem_bridge_if.master per,
    output logic                   sram_cs_o,
    output logic                   sram_we_o,
    output logic [3:0]             sram_be_o,
    output logic [SRAM_AW-1:0]     sram_addr_o,
    output logic [31:0]            sram_wdata_o,
    input  logic [31:0]            sram_rdata_i
);

    dmem_state_t state_q, state_d;
    logic        we_q, we_d;
    dmem_tgt_e   tgt;
    logic        accept;
    logic        gnt, rvalid, err, cs, per_req;
    logic [31:0] rdata;

    zeroriscy_dmem_decode #(
        .SRAM_AW   (SRAM_AW),
        .SRAM_BASE (SRAM_BASE),
        .PER_BASE  (PER_BASE),
        .PER_MASK  (PER_MASK)
    ) u_decode (
        .addr_i (data.addr),
        .tgt_o  (tgt)
    );

    assign accept = (state_q == StIdle) || (state_q == StSramRsp) || (state_q == StErrRsp);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        gnt     = 1'b0;
        rvalid  = 1'b0;
        err     = 1'b0;
        rdata   = 32'h0;
        cs      = 1'b0;
        per_req = 1'b0;

        // Response side of the current state
        case (state_q)
            StSramRsp: begin
                rvalid = 1'b1;
                rdata  = we_q ? 32'h0 : sram_rdata_i;
            end
            StErrRsp: begin
                rvalid = 1'b1;
                err    = 1'b1;
            end
            StPerWait: begin
                per_req = 1'b1;
                gnt     = per.gnt;
                if (per.gnt) state_d = StPerRsp;
            end
            StPerRsp: begin
                if (per.rvalid) begin
                    rvalid  = 1'b1;
                    err     = per.err;
                    rdata   = per.rdata;
                    state_d = StIdle;
                end
            end
            default: ;
        endcase

        // Request side: overlaps with the SRAM/error response cycle
        if (accept) begin
            state_d = StIdle;
            if (data.req) begin
                we_d = data.we;
                case (tgt)
                    TgtSram: begin
                        gnt     = 1'b1;
                        cs      = 1'b1;
                        state_d = StSramRsp;
                    end
                    TgtPer: begin
                        per_req = 1'b1;
                        gnt     = per.gnt;
                        state_d = per.gnt ? StPerRsp : StPerWait;
                    end
                    default: begin
                        gnt     = 1'b1;
                        state_d = StErrRsp;
                    end
                endcase
            end
        end

        if (rst) begin
            gnt     = 1'b0;
            rvalid  = 1'b0;
            err     = 1'b0;
            rdata   = 32'h0;
            cs      = 1'b0;
            per_req = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
        end
    end

    assign data.gnt    = gnt;
    assign data.rvalid = rvalid;
    assign data.err    = err;
    assign data.rdata  = rdata;

    assign sram_cs_o    = cs;
    assign sram_we_o    = cs & data.we;
    assign sram_be_o    = data.be;
    assign sram_addr_o  = data.addr[SRAM_AW+1:2];
    assign sram_wdata_o = data.wdata;

    assign per.req   = per_req;
    assign per.addr  = data.addr;
    assign per.we    = data.we;
    assign per.be    = data.be;
    assign per.wdata = data.wdata;

endmodule
